// File: rtl/alarm_controller_if.sv
// rtl/alarm_controller_if.sv - button, watch-time and alarm status signals of alarm_controller
//
// Purpose: groups the board-side inputs and the alarm status outputs of alarm_controller.
// Ports (master = board/watch side, slave = alarm_controller):
//   alarm_en         master->slave  level, 1 = alarm enabled
//   mode_btn         master->slave  pulse, toggles edit target WATCH <-> ALARM
//   edit_btns[1:0]   master->slave  pulses, [1] = hours+1, [0] = minutes+1
//   stop_btn         master->slave  pulse, stops ringing or snooze
//   snooze_btn       master->slave  pulse, snoozes while ringing
//   current_time     master->slave  BCD {Ht,Hu,Mt,Mu,St,Su} watch time
//   watch_edit_btns  slave->master  edit pulses forwarded to the watch
//   alarm_time       slave->master  BCD alarm time, seconds always 0
//   alarm_mode       slave->master  1 = edits target the alarm register
//   ringing          slave->master  1 while ringing
//   snoozing         slave->master  1 while snoozing
interface alarm_controller_if;
  logic        alarm_en;
  logic        mode_btn;
  logic [1:0]  edit_btns;
  logic        stop_btn;
  logic        snooze_btn;
  logic [19:0] current_time;
  logic [1:0]  watch_edit_btns;
  logic [19:0] alarm_time;
  logic        alarm_mode;
  logic        ringing;
  logic        snoozing;

  modport master (
    output alarm_en, mode_btn, edit_btns, stop_btn, snooze_btn, current_time,
    input  watch_edit_btns, alarm_time, alarm_mode, ringing, snoozing
  );

  modport slave (
    input  alarm_en, mode_btn, edit_btns, stop_btn, snooze_btn, current_time,
    output watch_edit_btns, alarm_time, alarm_mode, ringing, snoozing
  );
endinterface

// File: rtl/alarm_controller.sv
// rtl/alarm_controller.sv - alarm edit routing, time match and ring/snooze state machine
//
// Purpose: routes hour/minute edit pulses to the watch or to a BCD alarm register, compares
// the watch time with the alarm time and sequences DISARMED/ARMED/RINGING/SNOOZE.
// Second ticks come from changes of the seconds-units digit of current_time.
// Parameters:
//   RING_SECS    ticks RINGING may last before returning to ARMED (>=1)
//   SNOOZE_SECS  ticks spent in SNOOZE before ringing again (>=1)
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    alarm_controller_if.slave (buttons and watch time in, alarm status out)
module alarm_controller #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic                  clk,
  input  logic                  reset,
  alarm_controller_if.slave     bus
);

  localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int CNT_W    = $clog2(MAX_SECS + 1);
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] sec_cnt;
  logic [3:0]       prev_su;
  logic             match_q;

  // Alarm register, one BCD digit per field
  logic [1:0] al_ht;
  logic [3:0] al_hu;
  logic [2:0] al_mt;
  logic [3:0] al_mu;

  logic sec_tick;
  logic match;
  logic trig;

  assign sec_tick = (bus.current_time[3:0] != prev_su);
  assign match    = (bus.current_time[19:7] == {al_ht, al_hu, al_mt, al_mu}) &&
                    (bus.current_time[6:0] == 7'd0);
  // One trigger per match second; a stop inside that second cannot re-arm a ring
  assign trig     = match & ~match_q;

  assign bus.alarm_time = {al_ht, al_hu, al_mt, al_mu, 7'd0};

  // Edit routing and alarm register; mode_btn acts at the same edge, so a
  // simultaneous edit still lands in the previous target.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.alarm_mode      <= 1'b0;
      bus.watch_edit_btns <= 2'b00;
      al_ht               <= 2'd0;
      al_hu               <= 4'd0;
      al_mt               <= 3'd0;
      al_mu               <= 4'd0;
    end else begin
      bus.watch_edit_btns <= bus.alarm_mode ? 2'b00 : bus.edit_btns;
      if (bus.alarm_mode && bus.edit_btns[1]) begin
        if (al_ht == 2'd2 && al_hu == 4'd3) begin
          al_ht <= 2'd0;
          al_hu <= 4'd0;
        end else if (al_hu == 4'd9) begin
          al_ht <= al_ht + 2'd1;
          al_hu <= 4'd0;
        end else begin
          al_hu <= al_hu + 4'd1;
        end
      end
      // Minute wrap deliberately does not carry into hours
      if (bus.alarm_mode && bus.edit_btns[0]) begin
        if (al_mt == 3'd5 && al_mu == 4'd9) begin
          al_mt <= 3'd0;
          al_mu <= 4'd0;
        end else if (al_mu == 4'd9) begin
          al_mt <= al_mt + 3'd1;
          al_mu <= 4'd0;
        end else begin
          al_mu <= al_mu + 4'd1;
        end
      end
      if (bus.mode_btn) begin
        bus.alarm_mode <= ~bus.alarm_mode;
      end
    end
  end

  // Alarm FSM with registered ringing/snoozing that follow the state on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= DISARMED;
      sec_cnt      <= '0;
      prev_su      <= 4'd0;
      match_q      <= 1'b0;
      bus.ringing  <= 1'b0;
      bus.snoozing <= 1'b0;
    end else begin
      prev_su <= bus.current_time[3:0];
      match_q <= match;
      if (!bus.alarm_en) begin
        state        <= DISARMED;
        bus.ringing  <= 1'b0;
        bus.snoozing <= 1'b0;
      end else begin
        case (state)
          DISARMED: begin
            state <= ARMED;
          end
          ARMED: begin
            if (trig) begin
              state       <= RINGING;
              sec_cnt     <= '0;
              bus.ringing <= 1'b1;
            end
          end
          RINGING: begin
            if (bus.stop_btn) begin
              state       <= ARMED;
              bus.ringing <= 1'b0;
            end else if (bus.snooze_btn) begin
              state        <= SNOOZE;
              sec_cnt      <= '0;
              bus.ringing  <= 1'b0;
              bus.snoozing <= 1'b1;
            end else if (sec_tick && sec_cnt == RING_LAST) begin
              state       <= ARMED;
              bus.ringing <= 1'b0;
            end else if (sec_tick) begin
              sec_cnt <= sec_cnt + CNT_W'(1);
            end
          end
          SNOOZE: begin
            if (bus.stop_btn) begin
              state        <= ARMED;
              bus.snoozing <= 1'b0;
            end else if (sec_tick && sec_cnt == SNOOZE_LAST) begin
              state        <= RINGING;
              sec_cnt      <= '0;
              bus.ringing  <= 1'b1;
              bus.snoozing <= 1'b0;
            end else if (sec_tick) begin
              sec_cnt <= sec_cnt + CNT_W'(1);
            end
          end
          default: begin
            state        <= DISARMED;
            bus.ringing  <= 1'b0;
            bus.snoozing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// tb/tb_alarm_controller.sv - scoreboard bench for alarm_controller with a time-of-day reference model
module tb_alarm_controller;

  localparam int RING_SECS   = 2;
  localparam int SNOOZE_SECS = 3;
  localparam int T_ALARM     = 7 * 3600 + 30 * 60;

  localparam int S_DIS  = 0;
  localparam int S_ARM  = 1;
  localparam int S_RING = 2;
  localparam int S_SNZ  = 3;

  logic clk;
  logic reset;

  alarm_controller_if bus ();

  alarm_controller #(
    .RING_SECS  (RING_SECS),
    .SNOOZE_SECS(SNOOZE_SECS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus variables
  bit       s_rst;
  bit       s_en;
  bit       s_mode;
  bit [1:0] s_ed;
  bit       s_stop;
  bit       s_snz;
  int       s_t;

  // Reference model: alarm as plain hours/minutes, watch as seconds of day
  bit       m_mode;
  int       ah, am;
  int       m_st;
  int       m_ticks;
  int       prev_su;
  bit       match_q;
  bit [1:0] wedit;

  logic [24:0] exp_q[$];
  int n_tests;
  int n_fail;
  int n_cycle;

  function automatic logic [19:0] to_bcd(int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_step(output logic [24:0] e);
    int h, m, s, su;
    bit tick, match, trig;
    if (s_rst) begin
      m_mode = 0; ah = 0; am = 0; m_st = S_DIS; m_ticks = 0;
      prev_su = 0; match_q = 0; wedit = 2'b00;
    end else begin
      h = s_t / 3600;
      m = (s_t / 60) % 60;
      s = s_t % 60;
      su = s % 10;
      tick  = (su != prev_su);
      match = (h == ah) && (m == am) && (s == 0);
      trig  = match && !match_q;
      wedit = m_mode ? 2'b00 : s_ed;
      if (m_mode) begin
        if (s_ed[1]) ah = (ah + 1) % 24;
        if (s_ed[0]) am = (am + 1) % 60;
      end
      if (s_mode) m_mode = !m_mode;
      if (!s_en) begin
        m_st = S_DIS;
      end else begin
        case (m_st)
          S_DIS: m_st = S_ARM;
          S_ARM: if (trig) begin m_st = S_RING; m_ticks = 0; end
          S_RING: begin
            if (s_stop) m_st = S_ARM;
            else if (s_snz) begin m_st = S_SNZ; m_ticks = 0; end
            else if (tick) begin
              m_ticks++;
              if (m_ticks >= RING_SECS) m_st = S_ARM;
            end
          end
          default: begin
            if (s_stop) m_st = S_ARM;
            else if (tick) begin
              m_ticks++;
              if (m_ticks >= SNOOZE_SECS) begin m_st = S_RING; m_ticks = 0; end
            end
          end
        endcase
      end
      prev_su = su;
      match_q = match;
    end
    e = {wedit, 2'(ah / 10), 4'(ah % 10), 3'(am / 10), 4'(am % 10), 7'd0,
         m_mode, (m_st == S_RING), (m_st == S_SNZ)};
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the next edge
  task automatic cyc();
    logic [24:0] e;
    @(posedge clk);
    #2;
    reset            = s_rst;
    bus.alarm_en     = s_en;
    bus.mode_btn     = s_mode;
    bus.edit_btns    = s_ed;
    bus.stop_btn     = s_stop;
    bus.snooze_btn   = s_snz;
    bus.current_time = to_bcd(s_t);
    model_step(e);
    exp_q.push_back(e);
    s_mode = 0; s_ed = 2'b00; s_stop = 0; s_snz = 0;
  endtask

  task automatic hold(int t, int n);
    s_t = t;
    repeat (n) cyc();
  endtask

  // Monitor: every edge presents a full output word, compared against the oldest expectation
  initial begin
    logic [24:0] e, got;
    n_cycle = 0;
    forever begin
      @(posedge clk);
      #1;
      n_cycle++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.watch_edit_btns, bus.alarm_time, bus.alarm_mode, bus.ringing, bus.snoozing};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got wedit=%b alarm=%h mode=%b ring=%b snz=%b, expected wedit=%b alarm=%h mode=%b ring=%b snz=%b",
                   n_cycle, got[24:23], got[22:3], got[2], got[1], got[0],
                   e[24:23], e[22:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.alarm_en = 0; bus.mode_btn = 0; bus.edit_btns = 0;
    bus.stop_btn = 0; bus.snooze_btn = 0; bus.current_time = 20'h0;
    s_rst = 1; s_en = 0; s_mode = 0; s_ed = 0; s_stop = 0; s_snz = 0; s_t = 0;

    // Reset, then watch-mode edit forwarding
    cyc(); cyc();
    s_rst = 0;
    cyc();
    s_ed = 2'b10; cyc(); cyc(); cyc();

    // Alarm edits up to 23:59, then both bits wrap to 00:00
    s_mode = 1; cyc();
    repeat (23) begin s_ed = 2'b10; cyc(); end
    repeat (59) begin s_ed = 2'b01; cyc(); end
    s_ed = 2'b11; cyc(); cyc();

    // mode and edit together: edit goes to the old (alarm) target
    s_mode = 1; s_ed = 2'b01; cyc();
    s_mode = 1; cyc();
    repeat (7)  begin s_ed = 2'b10; cyc(); end
    repeat (29) begin s_ed = 2'b01; cyc(); end
    s_mode = 1; cyc();

    // Ring at 07:30 and time out after RING_SECS ticks
    s_en = 1;
    hold(T_ALARM - 10, 3);
    hold(T_ALARM - 1, 2);
    hold(T_ALARM, 2);
    hold(T_ALARM + 1, 2);
    hold(T_ALARM + 2, 2);

    // Stop inside the match second, no retrigger while held
    hold(T_ALARM - 1, 2);
    hold(T_ALARM, 2);
    s_stop = 1; cyc();
    hold(T_ALARM, 3);

    // Snooze for SNOOZE_SECS ticks, then stop+snooze together
    hold(T_ALARM - 1, 2);
    hold(T_ALARM, 2);
    s_snz = 1; cyc();
    hold(T_ALARM + 1, 2);
    hold(T_ALARM + 2, 2);
    hold(T_ALARM + 3, 2);
    s_stop = 1; s_snz = 1; cyc();
    hold(T_ALARM + 4, 2);

    // Disable while ringing
    hold(T_ALARM - 1, 2);
    hold(T_ALARM, 2);
    s_en = 0; cyc();
    s_en = 1; cyc(); cyc();

    // Reset mid-ring
    hold(T_ALARM - 1, 2);
    hold(T_ALARM, 2);
    s_rst = 1; cyc();
    s_rst = 0; cyc(); cyc();

    // Randomized phase
    s_en = 1;
    for (int i = 0; i < 4000; i++) begin
      s_rst  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) == 0) s_en = !s_en;
      s_mode = ($urandom_range(0, 39) == 0);
      s_ed   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s_stop = ($urandom_range(0, 59) == 0);
      s_snz  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 119) == 0)
        s_t = (ah * 3600 + am * 60 - int'($urandom_range(0, 3)) + 86400) % 86400;
      else if ($urandom_range(0, 2) == 0)
        s_t = (s_t + 1) % 86400;
      cyc();
    end
    s_rst = 0;
    cyc();

    repeat (2) @(posedge clk);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
